mips_load_store_unit: RTL and testbench

Multi-cycle load/store unit between the MEM-stage control of the MIPS datapath and the byte-addressed data memory. It accepts one load/store request at a time and presents word-aligned accesses to the memory. It sign- or zero-extends sub-word loads. Sub-word stores are performed as a read-modify-write so the memory only ever sees full-word writes. Misaligned and unsupported requests are rejected with an error response and never reach memory.

---
 rtl/mips_load_store_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mips_load_store_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_load_store_unit.sv
// ============================================================================
// Module   : mips_load_store_unit
// Brief    : Multi-cycle MIPS load/store unit with sub-word extension and
//            read-modify-write for byte/halfword stores (big-endian lanes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] mem_read_data
);

    localparam logic [5:0] c_op_lb  = 6'h20;
    localparam logic [5:0] c_op_lh  = 6'h21;
    localparam logic [5:0] c_op_lw  = 6'h23;
    localparam logic [5:0] c_op_lbu = 6'h24;
    localparam logic [5:0] c_op_lhu = 6'h25;
    localparam logic [5:0] c_op_sb  = 6'h28;
    localparam logic [5:0] c_op_sh  = 6'h29;
    localparam logic [5:0] c_op_sw  = 6'h2B;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_rd     = 3'd1;
    localparam logic [2:0] c_st_wr     = 3'd2;
    localparam logic [2:0] c_st_rmw_rd = 3'd3;
    localparam logic [2:0] c_st_rmw_wr = 3'd4;
    localparam logic [2:0] c_st_resp   = 3'd5;
    localparam logic [2:0] c_st_err    = 3'd6;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [5:0]  r_opcode;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_legal;
    logic        w_misaligned;
    logic        w_is_load;
    logic        w_is_sw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    assign w_accept = req_valid && req_ready;

    // Request decode: legality, alignment and access class of the incoming opcode
    always_comb begin
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        w_is_load    = 1'b0;
        w_is_sw      = 1'b0;
        case (req_opcode)
            c_op_lb, c_op_lbu: begin
                w_legal   = 1'b1;
                w_is_load = 1'b1;
            end
            c_op_lh, c_op_lhu: begin
                w_legal      = 1'b1;
                w_is_load    = 1'b1;
                w_misaligned = req_addr[0];
            end
            c_op_lw: begin
                w_legal      = 1'b1;
                w_is_load    = 1'b1;
                w_misaligned = |req_addr[1:0];
            end
            c_op_sb: begin
                w_legal = 1'b1;
            end
            c_op_sh: begin
                w_legal      = 1'b1;
                w_misaligned = req_addr[0];
            end
            c_op_sw: begin
                w_legal      = 1'b1;
                w_is_sw      = 1'b1;
                w_misaligned = |req_addr[1:0];
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_state_next = c_st_idle;
        case (r_state)
            c_st_idle: begin
                if (!w_accept) begin
                    w_state_next = c_st_idle;
                end else if (!w_legal || w_misaligned) begin
                    w_state_next = c_st_err;
                end else if (w_is_load) begin
                    w_state_next = c_st_rd;
                end else if (w_is_sw) begin
                    w_state_next = c_st_wr;
                end else begin
                    w_state_next = c_st_rmw_rd;
                end
            end
            c_st_rd:     w_state_next = c_st_resp;
            c_st_wr:     w_state_next = c_st_resp;
            c_st_rmw_rd: w_state_next = c_st_rmw_wr;
            c_st_rmw_wr: w_state_next = c_st_resp;
            c_st_resp:   w_state_next = c_st_idle;
            c_st_err:    w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    // Lane k of the big-endian word lives at bits [31-8k:24-8k]
    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = mem_read_data[31:24];
            2'd1:    w_byte = mem_read_data[23:16];
            2'd2:    w_byte = mem_read_data[15:8];
            default: w_byte = mem_read_data[7:0];
        endcase
        w_half = r_addr[1] ? mem_read_data[15:0] : mem_read_data[31:16];
    end

    always_comb begin
        w_load_ext = mem_read_data;
        case (r_opcode)
            c_op_lb:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_load_ext = {24'h000000, w_byte};
            c_op_lh:  w_load_ext = {{16{w_half[15]}}, w_half};
            c_op_lhu: w_load_ext = {16'h0000, w_half};
            default:  w_load_ext = mem_read_data;
        endcase
    end

    always_comb begin
        w_merged = r_merge;
        if (r_opcode == c_op_sh) begin
            if (r_addr[1]) begin
                w_merged[15:0] = r_wdata[15:0];
            end else begin
                w_merged[31:16] = r_wdata[15:0];
            end
        end else begin
            case (r_addr[1:0])
                2'd0:    w_merged[31:24] = r_wdata[7:0];
                2'd1:    w_merged[23:16] = r_wdata[7:0];
                2'd2:    w_merged[15:8]  = r_wdata[7:0];
                default: w_merged[7:0]   = r_wdata[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_opcode <= 6'h00;
            r_addr   <= 32'h0000_0000;
            r_wdata  <= 32'h0000_0000;
            r_merge  <= 32'h0000_0000;
            r_rdata  <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_opcode <= req_opcode;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_rdata  <= 32'h0000_0000;
            end
            if (r_state == c_st_rd) begin
                r_rdata <= w_load_ext;
            end
            if (r_state == c_st_rmw_rd) begin
                r_merge <= mem_read_data;
            end
        end
    end

    // Strobes and response are gated by reset so an aborted access is silent
    assign req_ready     = (r_state == c_st_idle);
    assign sig_mem_read  = !reset && ((r_state == c_st_rd) || (r_state == c_st_rmw_rd));
    assign sig_mem_write = !reset && ((r_state == c_st_wr) || (r_state == c_st_rmw_wr));
    assign resp_valid    = !reset && ((r_state == c_st_resp) || (r_state == c_st_err));
    assign resp_error    = !reset && (r_state == c_st_err);
    assign resp_rdata    = r_rdata;
    assign mem_address   = {r_addr[31:2], 2'b00};

    always_comb begin
        mem_write_data = 32'h0000_0000;
        if (r_state == c_st_wr) begin
            mem_write_data = r_wdata;
        end else if (r_state == c_st_rmw_wr) begin
            mem_write_data = w_merged;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_load_store_unit.sv
// ============================================================================
// Module   : tb_mips_load_store_unit
// Brief    : Self-checking bench: directed vector table, reset/back-to-back
//            sequences and random traffic against a byte-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mips_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        sig_mem_read;
    logic        sig_mem_write;
    logic [31:0] mem_read_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_load_store_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .sig_mem_read   (sig_mem_read),
        .sig_mem_write  (sig_mem_write),
        .mem_read_data  (mem_read_data)
    );

    // Environment memory: 256 words, aliased on address bits [9:2]
    logic [31:0] tb_mem [0:255];
    assign mem_read_data = tb_mem[mem_address[9:2]];
    always @(posedge clk) begin
        if (sig_mem_write) tb_mem[mem_address[9:2]] <= mem_write_data;
    end

    // Reference model state: the same 1 KiB viewed as bytes, lowest address = MSB
    logic [7:0] sh [0:1023];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er, output int lat,
                             output int nrd, output int nwr, output logic [31:0] wword);
        int b;
        int w;
        b = int'(a[9:0]);
        w = b - (b % 4);
        rd = 0; er = 0; nrd = 0; nwr = 0; wword = 0; lat = 2;
        case (op)
            6'h20, 6'h24, 6'h28: er = 0;
            6'h21, 6'h25, 6'h29: er = (b % 2) != 0;
            6'h23, 6'h2B:        er = (b % 4) != 0;
            default:             er = 1;
        endcase
        if (er) begin
            lat = 1;
        end else begin
            case (op)
                6'h20: rd = 32'($signed(sh[b]));
                6'h24: rd = 32'(sh[b]);
                6'h21: rd = 32'($signed({sh[b], sh[b+1]}));
                6'h25: rd = 32'({sh[b], sh[b+1]});
                6'h23: rd = {sh[b], sh[b+1], sh[b+2], sh[b+3]};
                6'h28: sh[b] = wd[7:0];
                6'h29: begin sh[b] = wd[15:8]; sh[b+1] = wd[7:0]; end
                default: begin
                    sh[b] = wd[31:24]; sh[b+1] = wd[23:16];
                    sh[b+2] = wd[15:8]; sh[b+3] = wd[7:0];
                end
            endcase
            nrd = (op == 6'h2B) ? 0 : 1;
            nwr = (op >= 6'h28) ? 1 : 0;
            lat = (op == 6'h28 || op == 6'h29) ? 3 : 2;
            if (nwr == 1) wword = {sh[w], sh[w+1], sh[w+2], sh[w+3]};
        end
    endtask

    task automatic run_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int nrd, output int nwr, output logic [31:0] waddr,
                           output logic [31:0] wword, output logic both);
        int  guard;
        logic done;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_opcode = op; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_opcode = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 1; nrd = 0; nwr = 0; both = 0; rd = 0; er = 0; waddr = 0; wword = 0; done = 0;
        while (!done && lat <= 8) begin
            if (sig_mem_read) nrd++;
            if (sig_mem_write) begin
                nwr++;
                waddr = mem_address;
                wword = mem_write_data;
            end
            if (sig_mem_read && sig_mem_write) both = 1;
            if (resp_valid) begin
                rd = resp_rdata;
                er = resp_error;
                done = 1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!done) lat = 99;
        @(negedge clk);
        check("ready_after_resp", 32'(req_ready), 32'd1);
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wword;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, wword, waddr, e_rd, e_wword;
        logic        er, both, e_er;
        int          lat, nrd, nwr, e_lat, e_nrd, e_nwr;
        int          acc_cyc [2];
        int          resp_cyc [4];
        logic [31:0] resp_dat [4];
        int          n_acc, n_resp, n_wr_seen;
        logic        acc_prev;

        vecs[0]  = '{6'h20, 32'h11, 32'h0,        32'hFFFFFF99, 1'b0, 2, 1, 0, 32'h0};
        vecs[1]  = '{6'h24, 32'h11, 32'h0,        32'h00000099, 1'b0, 2, 1, 0, 32'h0};
        vecs[2]  = '{6'h23, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 2, 1, 0, 32'h0};
        vecs[3]  = '{6'h21, 32'h12, 32'h0,        32'hFFFFAABB, 1'b0, 2, 1, 0, 32'h0};
        vecs[4]  = '{6'h25, 32'h12, 32'h0,        32'h0000AABB, 1'b0, 2, 1, 0, 32'h0};
        vecs[5]  = '{6'h21, 32'h10, 32'h0,        32'hFFFF8899, 1'b0, 2, 1, 0, 32'h0};
        vecs[6]  = '{6'h28, 32'h13, 32'h12345677, 32'h0,        1'b0, 3, 1, 1, 32'h8899AA77};
        vecs[7]  = '{6'h23, 32'h10, 32'h0,        32'h8899AA77, 1'b0, 2, 1, 0, 32'h0};
        vecs[8]  = '{6'h29, 32'h10, 32'h0000CAFE, 32'h0,        1'b0, 3, 1, 1, 32'hCAFEAA77};
        vecs[9]  = '{6'h23, 32'h10, 32'h0,        32'hCAFEAA77, 1'b0, 2, 1, 0, 32'h0};
        vecs[10] = '{6'h29, 32'h11, 32'h5555,     32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[11] = '{6'h23, 32'h12, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[12] = '{6'h0F, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[13] = '{6'h2B, 32'h14, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
        vecs[14] = '{6'h23, 32'h14, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0};

        reset = 1'b1; req_valid = 1'b0; req_opcode = 6'h0; req_addr = 0; req_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = (i == 4) ? 32'h8899AABB : $urandom;
            tb_mem[i] <= w;
            sh[4*i] = w[31:24]; sh[4*i+1] = w[23:16]; sh[4*i+2] = w[15:8]; sh[4*i+3] = w[7:0];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_write_data", mem_write_data, 32'd0);
        check("rst_strobes", {30'd0, sig_mem_read, sig_mem_write}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, er, lat, nrd, nwr, waddr, wword, both);
            ref_model(vecs[i].op, vecs[i].addr, vecs[i].wdata, e_rd, e_er, e_lat, e_nrd, e_nwr, e_wword);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].err));
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_reads", i), nrd, vecs[i].nrd);
            check($sformatf("vec%0d_writes", i), nwr, vecs[i].nwr);
            check($sformatf("vec%0d_wdata", i), wword, vecs[i].wword);
            check($sformatf("vec%0d_waddr", i), waddr, (vecs[i].nwr != 0) ? {vecs[i].addr[31:2], 2'b00} : 32'h0);
            check($sformatf("vec%0d_both", i), 32'(both), 32'd0);
        end

        // Reset while SH 0x10 sits in its read phase
        @(negedge clk);
        req_valid = 1'b1; req_opcode = 6'h29; req_addr = 32'h10; req_wdata = 32'h1111;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_rmw_read", 32'(sig_mem_read), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_rst_read", 32'(sig_mem_read), 32'd0);
        check("abort_rst_write", 32'(sig_mem_write), 32'd0);
        check("abort_rst_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready_after", 32'(req_ready), 32'd1);
        n_wr_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (sig_mem_write || resp_valid) n_wr_seen++;
            @(negedge clk);
        end
        check("abort_silent", n_wr_seen, 0);
        run_req(6'h23, 32'h10, 32'h0, rd, er, lat, nrd, nwr, waddr, wword, both);
        check("abort_mem_unchanged", rd, 32'hCAFEAA77);

        // Continuous req_valid: second request must wait for the IDLE after RESP
        n_acc = 0; n_resp = 0; acc_prev = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid = 1'b1; req_opcode = 6'h23; req_addr = 32'h10; req_wdata = 0;
            end else if (acc_prev) begin
                if (n_acc == 1) begin
                    req_opcode = 6'h24; req_addr = 32'h13;
                end else begin
                    req_valid = 1'b0;
                end
            end
            acc_prev = 0;
            if (req_valid && req_ready && n_acc < 2) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                acc_prev = 1;
            end
            if (resp_valid && n_resp < 4) begin
                resp_cyc[n_resp] = c;
                resp_dat[n_resp] = resp_rdata;
                n_resp++;
            end
        end
        req_valid = 1'b0;
        check("b2b_accepts", n_acc, 2);
        check("b2b_resps", n_resp, 2);
        if (n_acc == 2) begin
            check("b2b_first_accept", acc_cyc[0], 0);
            check("b2b_second_accept", acc_cyc[1], 3);
        end
        if (n_resp == 2) begin
            check("b2b_first_resp", resp_cyc[0], 2);
            check("b2b_second_resp", resp_cyc[1], 5);
            check("b2b_first_data", resp_dat[0], 32'hCAFEAA77);
            check("b2b_second_data", resp_dat[1], 32'h00000077);
        end

        // Random traffic against the byte-array model
        for (int i = 0; i < 300; i++) begin
            logic [5:0]  op;
            logic [31:0] a, wd;
            int          pick;
            logic [5:0]  legal_ops [8];
            legal_ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
            pick = $urandom_range(0, 9);
            op = (pick < 8) ? legal_ops[pick] : 6'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op == 6'h23 || op == 6'h2B) a[1:0] = 2'b00;
                else if (op == 6'h21 || op == 6'h25 || op == 6'h29) a[0] = 1'b0;
            end
            wd = $urandom;
            run_req(op, a, wd, rd, er, lat, nrd, nwr, waddr, wword, both);
            ref_model(op, a, wd, e_rd, e_er, e_lat, e_nrd, e_nwr, e_wword);
            if ({rd, er, lat, nrd, nwr, wword, both} !== {e_rd, e_er, e_lat, e_nrd, e_nwr, e_wword, 1'b0}) begin
                $display("FAIL rand%0d op=%h addr=%h: got rd=%h err=%0d lat=%0d rds=%0d wrs=%0d wword=%h both=%0d expected rd=%h err=%0d lat=%0d rds=%0d wrs=%0d wword=%h",
                         i, op, a, rd, er, lat, nrd, nwr, wword, both, e_rd, e_er, e_lat, e_nrd, e_nwr, e_wword);
                n_bad++;
            end
            n_cmp++;
            if (e_nwr != 0) check($sformatf("rand%0d_waddr", i), waddr, {a[31:2], 2'b00});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
